// File: rtl/vec_feat_pkg.sv
// Shared definitions for the vector feature scheduler: function/mode codes,
// vector geometry, FSM state type and small merge/range helpers.
package vec_feat_pkg;

   localparam logic [1:0] VEC_FUNC_SIZE  = 2'b01;
   localparam logic [1:0] VEC_FUNC_ARIT  = 2'b10;

   localparam logic [1:0] VEC_MODE_OFF   = 2'b00;
   localparam logic [1:0] VEC_MODE_SIZE  = 2'b01;
   localparam logic [1:0] VEC_MODE_ARIT  = 2'b10;
   localparam logic [1:0] VEC_MODE_SPLIT = 2'b11;

   localparam int VEC_LEN  = 20;
   localparam int VEC_HALF = 10;
   localparam int VEC_W    = 160;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_ISSUE,
      ST_WAIT,
      ST_WB
   } sched_state_e;

   // In split mode each requester owns one half; the feature unit always
   // returns the updated half in the low 80 bits of its result.
   function automatic logic [VEC_W-1:0] merge_vec(
      input logic [1:0]       mode,
      input logic [1:0]       func,
      input logic [VEC_W-1:0] old_vec,
      input logic [VEC_W-1:0] res_vec
   );
      logic [VEC_W-1:0] m;
      m = res_vec;
      if (mode == VEC_MODE_SPLIT) begin
         if (func == VEC_FUNC_SIZE)
            m = {res_vec[VEC_W/2-1:0], old_vec[VEC_W/2-1:0]};
         else
            m = {old_vec[VEC_W-1:VEC_W/2], res_vec[VEC_W/2-1:0]};
      end
      return m;
   endfunction

   // Packet index is 1-based and must fit in the vector (or half vector).
   function automatic logic n_pkt_ok(
      input logic [1:0] mode,
      input logic [7:0] n_pkt
   );
      logic ok;
      if (n_pkt == 8'd0)
         ok = 1'b0;
      else if (mode == VEC_MODE_SPLIT)
         ok = (n_pkt <= 8'(VEC_HALF));
      else
         ok = (n_pkt <= 8'(VEC_LEN));
      return ok;
   endfunction

endpackage

// File: rtl/vec_rr_arb2.sv
// Two-requester round-robin arbiter with per-requester eligibility.
// Bit 0 = size requester, bit 1 = arit requester. The grant is combinational
// and already includes the request, so it doubles as the handshake.
module vec_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   input  logic [1:0] elig,
   output logic [1:0] gnt
);

   logic       ptr;
   logic [1:0] cand;

   assign cand = req & elig & {2{en}};

   // Pointer decides only on a true contention; single requests pass straight.
   always_comb begin
      gnt = cand;
      if (cand == 2'b11)
         gnt = ptr ? 2'b10 : 2'b01;
   end

   // Pointer flips after every grant and starts on the size requester.
   always_ff @(posedge clk) begin
      if (!rst_n)
         ptr <= 1'b0;
      else if (|gnt)
         ptr <= ~ptr;
   end

endmodule

// File: rtl/vec_feature_sched.sv
// Sequencer/arbiter in front of the vector feature unit: grants one
// requester, reads the flow history, issues one update, merges the result
// and writes it back. Optional statistics counters: VEC_SCHED_STATS_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | arbitrate, capture request, range-check n_pkt
// ST_RD    | RAM read strobe for latched flow
// ST_ISSUE | history vector on the bus, feature unit strobe
// ST_WAIT  | wait for feature unit result, bounded by WAIT_TO
// ST_WB    | write merged vector back, done pulse
module vec_feature_sched
   import vec_feat_pkg::*;
#(
   parameter int         FLOW_AW = 10,
   parameter logic [7:0] THRESH  = 8'd20,
   parameter int         WAIT_TO = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         cfg_vec_mode,
   input  logic               sz_valid,
   output logic               sz_ready,
   input  logic [FLOW_AW-1:0] sz_flow_id,
   input  logic [7:0]         sz_n_pkt,
   input  logic [7:0]         sz_data,
   input  logic               ar_valid,
   output logic               ar_ready,
   input  logic [FLOW_AW-1:0] ar_flow_id,
   input  logic [7:0]         ar_n_pkt,
   input  logic [7:0]         ar_data,
   output logic               mem_rd_en,
   output logic [FLOW_AW-1:0] mem_rd_addr,
   input  logic [VEC_W-1:0]   mem_rd_data,
   output logic               mem_wr_en,
   output logic [FLOW_AW-1:0] mem_wr_addr,
   output logic [VEC_W-1:0]   mem_wr_data,
   output logic [7:0]         fu_n_pkt,
   output logic [7:0]         fu_cur_data,
   output logic               fu_cur_data_v,
   output logic [VEC_W-1:0]   fu_hist_vec,
   output logic [1:0]         fu_vec_func,
   output logic [1:0]         fu_vec_mode,
   input  logic [VEC_W-1:0]   fu_vec_feature,
   input  logic               fu_vec_feature_v,
   output logic               done_v,
   output logic [FLOW_AW-1:0] done_flow_id,
   output logic [VEC_W-1:0]   done_vec,
   output logic               done_thrh,
   output logic               err_drop
`ifdef VEC_SCHED_STATS_EN
   ,
   input  logic               stat_clr,
   output logic [31:0]        stat_sz_cnt,
   output logic [31:0]        stat_ar_cnt,
   output logic [15:0]        stat_drop_cnt
`endif
);

   localparam int TO_W = (WAIT_TO < 2) ? 1 : $clog2(WAIT_TO);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(WAIT_TO - 1);

   sched_state_e       state;
   logic [FLOW_AW-1:0] lat_flow;
   logic [7:0]         lat_n;
   logic [7:0]         lat_data;
   logic [1:0]         lat_func;
   logic [1:0]         lat_mode;
   logic [VEC_W-1:0]   old_vec;
   logic [TO_W-1:0]    to_cnt;

   logic [1:0]         gnt;
   logic [1:0]         elig;
   logic               arb_en;
   logic [FLOW_AW-1:0] sel_flow;
   logic [7:0]         sel_n;
   logic [7:0]         sel_data;
   logic [VEC_W-1:0]   merged_vec;

   assign elig[0] = (cfg_vec_mode == VEC_MODE_SIZE) || (cfg_vec_mode == VEC_MODE_SPLIT);
   assign elig[1] = (cfg_vec_mode == VEC_MODE_ARIT) || (cfg_vec_mode == VEC_MODE_SPLIT);
   // No ready while reset is asserted, so nothing looks accepted that is not.
   assign arb_en  = (state == ST_IDLE) && rst_n;

   vec_rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (arb_en),
      .req   ({ar_valid, sz_valid}),
      .elig  (elig),
      .gnt   (gnt)
   );

   assign sz_ready = gnt[0];
   assign ar_ready = gnt[1];

   assign sel_flow = gnt[1] ? ar_flow_id : sz_flow_id;
   assign sel_n    = gnt[1] ? ar_n_pkt   : sz_n_pkt;
   assign sel_data = gnt[1] ? ar_data    : sz_data;

   // RAM data arrives in ISSUE and goes straight through to the feature unit.
   assign fu_hist_vec = fu_cur_data_v ? mem_rd_data : '0;

   assign merged_vec = merge_vec(lat_mode, lat_func, old_vec, fu_vec_feature);

   // Sequencer: state, request latches, timeout counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         lat_flow      <= '0;
         lat_n         <= '0;
         lat_data      <= '0;
         lat_func      <= '0;
         lat_mode      <= '0;
         old_vec       <= '0;
         to_cnt        <= '0;
         mem_rd_en     <= 1'b0;
         mem_rd_addr   <= '0;
         mem_wr_en     <= 1'b0;
         mem_wr_addr   <= '0;
         mem_wr_data   <= '0;
         fu_n_pkt      <= '0;
         fu_cur_data   <= '0;
         fu_cur_data_v <= 1'b0;
         fu_vec_func   <= '0;
         fu_vec_mode   <= '0;
         done_v        <= 1'b0;
         done_flow_id  <= '0;
         done_vec      <= '0;
         done_thrh     <= 1'b0;
         err_drop      <= 1'b0;
      end else begin
         mem_rd_en     <= 1'b0;
         mem_rd_addr   <= '0;
         mem_wr_en     <= 1'b0;
         mem_wr_addr   <= '0;
         mem_wr_data   <= '0;
         fu_n_pkt      <= '0;
         fu_cur_data   <= '0;
         fu_cur_data_v <= 1'b0;
         fu_vec_func   <= '0;
         fu_vec_mode   <= '0;
         done_v        <= 1'b0;
         done_flow_id  <= '0;
         done_vec      <= '0;
         done_thrh     <= 1'b0;
         err_drop      <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (|gnt) begin
                  lat_flow <= sel_flow;
                  lat_n    <= sel_n;
                  lat_data <= sel_data;
                  lat_func <= gnt[1] ? VEC_FUNC_ARIT : VEC_FUNC_SIZE;
                  lat_mode <= cfg_vec_mode;
                  if (n_pkt_ok(cfg_vec_mode, sel_n)) begin
                     state       <= ST_RD;
                     mem_rd_en   <= 1'b1;
                     mem_rd_addr <= sel_flow;
                  end else begin
                     err_drop <= 1'b1;
                  end
               end
            end

            ST_RD: begin
               state         <= ST_ISSUE;
               fu_cur_data_v <= 1'b1;
               fu_n_pkt      <= lat_n;
               fu_cur_data   <= lat_data;
               fu_vec_func   <= lat_func;
               fu_vec_mode   <= lat_mode;
            end

            ST_ISSUE: begin
               old_vec <= mem_rd_data;
               to_cnt  <= TO_LOAD;
               state   <= ST_WAIT;
            end

            ST_WAIT: begin
               if (fu_vec_feature_v) begin
                  state        <= ST_WB;
                  mem_wr_en    <= 1'b1;
                  mem_wr_addr  <= lat_flow;
                  mem_wr_data  <= merged_vec;
                  done_v       <= 1'b1;
                  done_flow_id <= lat_flow;
                  done_vec     <= merged_vec;
                  done_thrh    <= (lat_n == THRESH);
               end else if (to_cnt == '0) begin
                  state    <= ST_IDLE;
                  err_drop <= 1'b1;
               end else begin
                  to_cnt <= to_cnt - 1'b1;
               end
            end

            ST_WB: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef VEC_SCHED_STATS_EN
   // Saturating activity counters: completed updates per function and drops.
   always_ff @(posedge clk) begin
      if (!rst_n || stat_clr) begin
         stat_sz_cnt   <= '0;
         stat_ar_cnt   <= '0;
         stat_drop_cnt <= '0;
      end else begin
         if (state == ST_WB && lat_func == VEC_FUNC_SIZE && stat_sz_cnt != '1)
            stat_sz_cnt <= stat_sz_cnt + 1'b1;
         if (state == ST_WB && lat_func == VEC_FUNC_ARIT && stat_ar_cnt != '1)
            stat_ar_cnt <= stat_ar_cnt + 1'b1;
         if (err_drop && stat_drop_cnt != '1)
            stat_drop_cnt <= stat_drop_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_vec_feature_sched.sv
// Directed and randomized bench for vec_feature_sched with a RAM model,
// a feature-unit stub and a byte-level expected-RAM reference.
module tb_vec_feature_sched;

   localparam int AW      = 10;
   localparam int WAIT_TO = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [1:0]         cfg_vec_mode;
   logic               sz_valid, sz_ready;
   logic [AW-1:0]      sz_flow_id;
   logic [7:0]         sz_n_pkt, sz_data;
   logic               ar_valid, ar_ready;
   logic [AW-1:0]      ar_flow_id;
   logic [7:0]         ar_n_pkt, ar_data;
   logic               mem_rd_en;
   logic [AW-1:0]      mem_rd_addr;
   logic [159:0]       mem_rd_data = '0;
   logic               mem_wr_en;
   logic [AW-1:0]      mem_wr_addr;
   logic [159:0]       mem_wr_data;
   logic [7:0]         fu_n_pkt, fu_cur_data;
   logic               fu_cur_data_v;
   logic [159:0]       fu_hist_vec;
   logic [1:0]         fu_vec_func, fu_vec_mode;
   logic [159:0]       fu_vec_feature = '0;
   logic               fu_vec_feature_v = 1'b0;
   logic               done_v;
   logic [AW-1:0]      done_flow_id;
   logic [159:0]       done_vec;
   logic               done_thrh;
   logic               err_drop;
`ifdef VEC_SCHED_STATS_EN
   logic               stat_clr = 1'b0;
   logic [31:0]        stat_sz_cnt, stat_ar_cnt;
   logic [15:0]        stat_drop_cnt;
`endif

   int total = 0;
   int bad   = 0;

   logic [159:0] ram     [0:1023];
   logic [159:0] exp_ram [0:1023];
   logic         ram_clr  = 1'b1;
   logic         withhold = 1'b0;

   always #5 clk = ~clk;

   vec_feature_sched dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cfg_vec_mode     (cfg_vec_mode),
      .sz_valid         (sz_valid),
      .sz_ready         (sz_ready),
      .sz_flow_id       (sz_flow_id),
      .sz_n_pkt         (sz_n_pkt),
      .sz_data          (sz_data),
      .ar_valid         (ar_valid),
      .ar_ready         (ar_ready),
      .ar_flow_id       (ar_flow_id),
      .ar_n_pkt         (ar_n_pkt),
      .ar_data          (ar_data),
      .mem_rd_en        (mem_rd_en),
      .mem_rd_addr      (mem_rd_addr),
      .mem_rd_data      (mem_rd_data),
      .mem_wr_en        (mem_wr_en),
      .mem_wr_addr      (mem_wr_addr),
      .mem_wr_data      (mem_wr_data),
      .fu_n_pkt         (fu_n_pkt),
      .fu_cur_data      (fu_cur_data),
      .fu_cur_data_v    (fu_cur_data_v),
      .fu_hist_vec      (fu_hist_vec),
      .fu_vec_func      (fu_vec_func),
      .fu_vec_mode      (fu_vec_mode),
      .fu_vec_feature   (fu_vec_feature),
      .fu_vec_feature_v (fu_vec_feature_v),
      .done_v           (done_v),
      .done_flow_id     (done_flow_id),
      .done_vec         (done_vec),
      .done_thrh        (done_thrh),
      .err_drop         (err_drop)
`ifdef VEC_SCHED_STATS_EN
      ,
      .stat_clr         (stat_clr),
      .stat_sz_cnt      (stat_sz_cnt),
      .stat_ar_cnt      (stat_ar_cnt),
      .stat_drop_cnt    (stat_drop_cnt)
`endif
   );

   // Feature unit stand-in: writes the byte at position n_pkt-1 of the vector,
   // or of the requester's half (returned in the low 80 bits) in split mode.
   function automatic logic [159:0] fu_model(input logic [159:0] hist, input logic [7:0] n,
                                             input logic [7:0] d, input logic [1:0] func,
                                             input logic [1:0] mode);
      logic [159:0] r;
      if (mode == 2'b11) begin
         r = '0;
         r[79:0] = (func == 2'b01) ? hist[159:80] : hist[79:0];
      end else begin
         r = hist;
      end
      r[8*(int'(n)-1) +: 8] = d;
      return r;
   endfunction

   // Reference: a valid update places its byte in packet slot n-1 of the flow
   // vector; in split mode size slots live in the upper 80 bits.
   function automatic logic [159:0] exp_update(input logic [159:0] old, input bit is_ar,
                                               input logic [1:0] mode, input int n,
                                               input logic [7:0] d);
      logic [159:0] e;
      int base;
      base = (mode == 2'b11 && !is_ar) ? 80 : 0;
      e = old;
      e[base + 8*(n-1) +: 8] = d;
      return e;
   endfunction

   // Flow-history RAM: one-cycle read latency.
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 1024; i++) ram[i] <= '0;
      end else begin
         if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
         if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
      end
   end

   // Feature unit responds one cycle after its strobe unless withheld.
   always @(posedge clk) begin
      fu_vec_feature_v <= 1'b0;
      if (fu_cur_data_v && !withhold) begin
         fu_vec_feature_v <= 1'b1;
         fu_vec_feature   <= fu_model(fu_hist_vec, fu_n_pkt, fu_cur_data, fu_vec_func, fu_vec_mode);
      end
   end

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      sz_valid = 1'b0;
      ar_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic drive(input bit is_ar, input logic [AW-1:0] f, input logic [7:0] n,
                        input logic [7:0] d);
      if (is_ar) begin
         ar_flow_id = f; ar_n_pkt = n; ar_data = d; ar_valid = 1'b1;
      end else begin
         sz_flow_id = f; sz_n_pkt = n; sz_data = d; sz_valid = 1'b1;
      end
   endtask

   // Returns the number of whole cycles waited before ready, -1 on timeout.
   task automatic wait_ready(input bit is_ar, output int cyc);
      cyc = -1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if ((is_ar ? ar_ready : sz_ready) === 1'b1) begin
            cyc = i;
            break;
         end
         @(posedge clk);
      end
      if (cyc < 0) chk("handshake_timeout", 0, 1);
   endtask

   // Called inside the handshake cycle T; checks T+1 .. T+5 (or drop path).
   task automatic run_pipe(input bit is_ar, input logic [AW-1:0] f, input logic [7:0] n,
                           input logic [7:0] d, input logic [1:0] mode);
      bit ok_n;
      logic [159:0] e;
      ok_n = (n != 0) && (int'(n) <= ((mode == 2'b11) ? 10 : 20));
      tick();
      if (is_ar) ar_valid = 1'b0; else sz_valid = 1'b0;
      if (!ok_n) begin
         chk("drop_err", err_drop, 1);
         chk("drop_no_rd", mem_rd_en, 0);
         tick();
         chk("drop_pulse_end", err_drop, 0);
         chk("drop_no_rd2", mem_rd_en, 0);
         chk("drop_no_wr", mem_wr_en, 0);
         return;
      end
      chk("rd_en", mem_rd_en, 1);
      chk("rd_addr", mem_rd_addr, f);
      chk("no_err", err_drop, 0);
      tick();
      chk("fu_v", fu_cur_data_v, 1);
      chk("fu_n_pkt", fu_n_pkt, n);
      chk("fu_data", fu_cur_data, d);
      chk("fu_func", fu_vec_func, is_ar ? 2'b10 : 2'b01);
      chk("fu_mode", fu_vec_mode, mode);
      chk("fu_hist", fu_hist_vec, exp_ram[f]);
      tick();
      chk("fu_v_off", fu_cur_data_v, 0);
      chk("fu_hist_off", fu_hist_vec, 0);
      chk("done_early", done_v, 0);
      tick();
      e = exp_update(exp_ram[f], is_ar, mode, int'(n), d);
      chk("done_v", done_v, 1);
      chk("wr_en", mem_wr_en, 1);
      chk("wr_addr", mem_wr_addr, f);
      chk("wr_data", mem_wr_data, e);
      chk("done_vec", done_vec, e);
      chk("done_flow", done_flow_id, f);
      chk("done_thrh", done_thrh, (n == 8'd20));
      exp_ram[f] = e;
      tick();
      chk("done_v_off", done_v, 0);
      chk("done_thrh_off", done_thrh, 0);
      chk("wr_en_off", mem_wr_en, 0);
      chk("ram_word", ram[f], exp_ram[f]);
   endtask

   initial begin
      int cyc;
      logic [159:0] w;
      logic [1:0] m;
      bit a;
      logic [AW-1:0] f;
      logic [7:0] n, d;

      rst_n = 1'b0;
      cfg_vec_mode = 2'b00;
      sz_valid = 1'b0; sz_flow_id = '0; sz_n_pkt = '0; sz_data = '0;
      ar_valid = 1'b0; ar_flow_id = '0; ar_n_pkt = '0; ar_data = '0;
      for (int i = 0; i < 1024; i++) exp_ram[i] = '0;
      tick();
      ram_clr = 1'b0;
      do_reset();

      chk("reset_outs", |{sz_ready, ar_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
                          mem_wr_data, fu_n_pkt, fu_cur_data, fu_cur_data_v, fu_hist_vec,
                          fu_vec_func, fu_vec_mode, done_v, done_flow_id, done_vec,
                          done_thrh, err_drop}, 0);

      // Mode off: nobody gets ready.
      drive(0, 10'd1, 8'd1, 8'h11);
      drive(1, 10'd1, 8'd1, 8'h22);
      #1;
      chk("off_sz_ready", sz_ready, 0);
      chk("off_ar_ready", ar_ready, 0);
      tick();
      chk("off_no_rd", mem_rd_en, 0);
      sz_valid = 1'b0; ar_valid = 1'b0;

      // Mode 01, size flow 5 pkt 3 data 0x40; arit held valid but ineligible.
      cfg_vec_mode = 2'b01;
      drive(1, 10'd7, 8'd1, 8'h99);
      drive(0, 10'd5, 8'd3, 8'h40);
      wait_ready(0, cyc);
      chk("t1_ar_ready", ar_ready, 0);
      run_pipe(0, 10'd5, 8'd3, 8'h40, 2'b01);
      chk("t1_ar_ready_end", ar_ready, 0);
      w = ram[5];
      chk("t1_byte2", w[23:16], 8'h40);
      chk("t1_rest", {w[159:24], w[15:0]}, 0);
      ar_valid = 1'b0;

      // Mode 11 contention from reset: size first, arit five cycles later.
      do_reset();
      cfg_vec_mode = 2'b11;
      drive(0, 10'd9, 8'd2, 8'hAA);
      drive(1, 10'd9, 8'd2, 8'h55);
      wait_ready(0, cyc);
      chk("t2_sz_first", cyc, 0);
      chk("t2_ar_blocked", ar_ready, 0);
      run_pipe(0, 10'd9, 8'd2, 8'hAA, 2'b11);
      wait_ready(1, cyc);
      chk("t2_ar_at_T5", cyc, 0);
      run_pipe(1, 10'd9, 8'd2, 8'h55, 2'b11);
      w = ram[9];
      chk("t2_size_half", w[95:88], 8'hAA);
      chk("t2_arit_half", w[15:8], 8'h55);

      // Mode 11 arit n_pkt 11 is out of range for a half vector.
      drive(1, 10'd4, 8'd11, 8'h07);
      wait_ready(1, cyc);
      run_pipe(1, 10'd4, 8'd11, 8'h07, 2'b11);
      chk("t3_ram_untouched", ram[4], exp_ram[4]);

      // Threshold packet.
      cfg_vec_mode = 2'b01;
      drive(0, 10'd6, 8'd20, 8'h99);
      wait_ready(0, cyc);
      run_pipe(0, 10'd6, 8'd20, 8'h99, 2'b01);

      // Feature unit never answers: timeout after WAIT_TO cycles in WAIT.
      withhold = 1'b1;
      drive(0, 10'd3, 8'd4, 8'h33);
      wait_ready(0, cyc);
      tick();
      sz_valid = 1'b0;
      tick();
      chk("to_issue", fu_cur_data_v, 1);
      for (int i = 0; i < WAIT_TO; i++) begin
         tick();
         chk("to_wait_no_err", err_drop, 0);
         chk("to_wait_no_wr", mem_wr_en | done_v, 0);
      end
      tick();
      chk("to_err", err_drop, 1);
      chk("to_no_wr", mem_wr_en, 0);
      tick();
      chk("to_err_end", err_drop, 0);
      chk("to_ram", ram[3], exp_ram[3]);
      withhold = 1'b0;
      drive(0, 10'd3, 8'd4, 8'h34);
      wait_ready(0, cyc);
      chk("to_back_idle", cyc, 0);
      run_pipe(0, 10'd3, 8'd4, 8'h34, 2'b01);

      // Reset asserted while in WAIT.
      drive(0, 10'd2, 8'd5, 8'h77);
      wait_ready(0, cyc);
      tick();
      sz_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("rst_wait_outs", |{sz_ready, ar_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
                             mem_wr_data, fu_n_pkt, fu_cur_data, fu_cur_data_v, fu_hist_vec,
                             fu_vec_func, fu_vec_mode, done_v, done_flow_id, done_vec,
                             done_thrh, err_drop}, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_no_wr", mem_wr_en, 0);
      tick();
      chk("rst_ram", ram[2], exp_ram[2]);
      drive(0, 10'd2, 8'd5, 8'h78);
      wait_ready(0, cyc);
      chk("rst_idle", cyc, 0);
      run_pipe(0, 10'd2, 8'd5, 8'h78, 2'b01);

      // Randomized single requests across modes, flows 0..7, n_pkt 0..22.
      for (int k = 0; k < 40; k++) begin
         m = 2'($urandom_range(1, 3));
         a = (m == 2'b10) ? 1'b1 : (m == 2'b01) ? 1'b0 : 1'($urandom_range(0, 1));
         f = AW'($urandom_range(0, 7));
         n = 8'($urandom_range(0, 22));
         d = 8'($urandom);
         cfg_vec_mode = m;
         drive(a, f, n, d);
         wait_ready(a, cyc);
         if (cyc >= 0) begin
            run_pipe(a, f, n, d, m);
         end else begin
            sz_valid = 1'b0;
            ar_valid = 1'b0;
         end
      end
      for (int i = 0; i < 8; i++) chk("final_ram", ram[i], exp_ram[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
